// File: rtl/aes_entropy_responder_if.sv
// rtl/aes_entropy_responder_if.sv - entropy request channel and seed port between requester and responder
interface aes_entropy_responder_if;
  logic         _ep_req_valid;
  logic         _ep_req_0;
  logic         _ep_req_ack;
  logic [127:0] _ep_res_0;
  logic         seed_valid_i;
  logic [127:0] seed_i;
  logic         seed_ack_o;
  logic         reseed_req_o;
  logic [31:0]  words_o;

  modport master (
    output _ep_req_valid, _ep_req_0, seed_valid_i, seed_i,
    input  _ep_req_ack, _ep_res_0, seed_ack_o, reseed_req_o, words_o
  );

  modport slave (
    input  _ep_req_valid, _ep_req_0, seed_valid_i, seed_i,
    output _ep_req_ack, _ep_res_0, seed_ack_o, reseed_req_o, words_o
  );
endinterface

// File: rtl/aes_entropy_responder.sv
// rtl/aes_entropy_responder.sv - LFSR-backed entropy responder for the AES cipher core request channel
module aes_entropy_responder #(
  parameter int unsigned  StepsPerWord   = 8,
  parameter int unsigned  ReseedInterval = 1024,
  parameter bit           StrictReseed   = 1'b1,
  parameter logic [127:0] DefaultSeed    = 128'h5A5A_A5A5_0123_4567_89AB_CDEF_F00D_CAFE
) (
  input logic                    clk_i,
  input logic                    rst_i,
  aes_entropy_responder_if.slave ep
);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [7:0]  LastStep   = 8'(StepsPerWord - 1);
  localparam logic [31:0] ReseedWord = 32'(ReseedInterval);

  logic [1:0]   state;
  logic [127:0] lfsr;
  logic [127:0] lfsr_next;
  logic [127:0] buffer;
  logic [7:0]   fill_cnt;
  logic [31:0]  words;
  logic         reseed_req;
  logic         ack;
  logic         seed_ack;
  logic         unused_req_0;

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction

  assign lfsr_next    = lfsr_step(lfsr);
  assign unused_req_0 = ep._ep_req_0;

  // A pending strict reseed masks the ack even in the one READY cycle before STALL.
  assign ack      = ep._ep_req_valid & (state == ST_READY) & ~(StrictReseed & reseed_req);
  assign seed_ack = ep.seed_valid_i & ~ack;

  assign ep._ep_req_ack  = ack;
  assign ep._ep_res_0    = buffer;
  assign ep.seed_ack_o   = seed_ack;
  assign ep.reseed_req_o = reseed_req;
  assign ep.words_o      = words;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_FILL;
      lfsr       <= DefaultSeed;
      buffer     <= '0;
      fill_cnt   <= '0;
      words      <= '0;
      reseed_req <= 1'b0;
    end else if (seed_ack) begin
      state      <= ST_FILL;
      lfsr       <= (ep.seed_i == '0) ? DefaultSeed : ep.seed_i;
      buffer     <= '0;
      fill_cnt   <= '0;
      words      <= '0;
      reseed_req <= 1'b0;
    end else begin
      if ((ReseedWord != '0) && (words == ReseedWord)) begin
        reseed_req <= 1'b1;
      end
      case (state)
        ST_FILL: begin
          lfsr <= lfsr_next;
          if (fill_cnt == LastStep) begin
            buffer   <= lfsr_next;
            fill_cnt <= '0;
            state    <= ST_READY;
          end else begin
            fill_cnt <= fill_cnt + 8'd1;
          end
        end
        ST_READY: begin
          if (ack) begin
            buffer <= '0;
            state  <= ST_FILL;
            if (words != 32'hFFFF_FFFF) begin
              words <= words + 32'd1;
            end
          end else if (StrictReseed && reseed_req) begin
            buffer <= '0;
            state  <= ST_STALL;
          end
        end
        ST_STALL: begin
          buffer <= '0;
        end
        default: begin
          buffer <= '0;
          state  <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_entropy_responder.sv
// tb/tb_aes_entropy_responder.sv - self-checking bench for aes_entropy_responder against a timing/word model
module tb_aes_entropy_responder;
  localparam int           S     = 3;
  localparam int           RI    = 3;
  localparam logic [127:0] DSEED = 128'h5A5A_A5A5_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam longint       INF   = 64'd1 << 40;

  logic clk;
  logic rst;
  aes_entropy_responder_if ep();

  aes_entropy_responder #(
    .StepsPerWord(S), .ReseedInterval(RI), .StrictReseed(1'b1), .DefaultSeed(DSEED)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ep(ep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           errors;
  int           checks;
  longint       cyc;
  logic [127:0] m_word;
  longint       m_ready_at;
  longint       m_reseed_at;
  logic [31:0]  m_words;

  function automatic logic [127:0] stepn(input logic [127:0] s, input int n);
    logic [127:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc         = 0;
    m_word      = stepn(DSEED, S);
    m_ready_at  = S;
    m_reseed_at = INF;
    m_words     = 0;
  endtask

  // One cycle: drive, compare against the model mid-cycle, then advance the model at the edge.
  task automatic step(input logic req, input logic sv, input logic [127:0] sd,
                      output logic got_ack, output logic [127:0] got_res, output logic sacked);
    logic         e_ack, e_sack, e_buf;
    longint       stall_from;
    logic [127:0] w;
    ep._ep_req_valid = req;
    ep._ep_req_0     = 1'($urandom);
    ep.seed_valid_i  = sv;
    ep.seed_i        = sd;
    #1;
    stall_from = ((m_ready_at > m_reseed_at) ? m_ready_at : m_reseed_at) + 1;
    e_buf  = (cyc >= m_ready_at) && (cyc < stall_from);
    e_ack  = req && (cyc >= m_ready_at) && (cyc < m_reseed_at);
    e_sack = sv && !e_ack;
    chk("ack", 128'(ep._ep_req_ack), 128'(e_ack));
    chk("res", ep._ep_res_0, e_buf ? m_word : 128'h0);
    chk("seed_ack", 128'(ep.seed_ack_o), 128'(e_sack));
    chk("reseed_req", 128'(ep.reseed_req_o), 128'(cyc >= m_reseed_at));
    chk("words", 128'(ep.words_o), 128'(m_words));
    got_ack = ep._ep_req_ack;
    got_res = ep._ep_res_0;
    sacked  = e_sack;
    @(posedge clk);
    if (e_sack) begin
      w           = (sd == '0) ? DSEED : sd;
      m_word      = stepn(w, S);
      m_ready_at  = cyc + 1 + S;
      m_words     = 0;
      m_reseed_at = INF;
    end else if (e_ack) begin
      m_word     = stepn(m_word, S);
      m_ready_at = cyc + S + 1;
      if (m_words != 32'hFFFF_FFFF) m_words = m_words + 1;
      if (RI != 0 && m_words == RI) m_reseed_at = cyc + 2;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    ep._ep_req_valid = 1'b1;
    ep.seed_valid_i  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ack", 128'(ep._ep_req_ack), 128'h0);
    chk("rst_res", ep._ep_res_0, 128'h0);
    chk("rst_seed_ack", 128'(ep.seed_ack_o), 128'h0);
    chk("rst_reseed", 128'(ep.reseed_req_o), 128'h0);
    chk("rst_words", 128'(ep.words_o), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic         ga, sk, sv_hold;
  logic [127:0] gr, sd_hold;

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    ep._ep_req_valid = 1'b0;
    ep._ep_req_0     = 1'b0;
    ep.seed_valid_i  = 1'b0;
    ep.seed_i        = '0;
    repeat (2) @(negedge clk);

    do_reset();
    ga = 1'b0;
    for (int i = 0; i < 20 && !ga; i++) step(1'b1, 1'b0, '0, ga, gr, sk);
    chk("first_ack_cycle", 128'(cyc - 1), 128'(S));
    chk("first_word", gr, stepn(DSEED, S));

    step(1'b0, 1'b1, 128'h1, ga, gr, sk);
    chk("seed1_accepted", 128'(sk), 128'h1);
    for (int i = 0; i <= S; i++) step(1'b1, 1'b0, '0, ga, gr, sk);
    chk("seed1_word0_ack", 128'(ga), 128'h1);
    chk("seed1_word0", gr, 128'h8);
    for (int i = 0; i <= S; i++) step(1'b1, 1'b0, '0, ga, gr, sk);
    chk("seed1_word1", gr, 128'h40);
    for (int i = 0; i <= S; i++) step(1'b1, 1'b0, '0, ga, gr, sk);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, ga, gr, sk);
    chk("stalled_reseed_req", 128'(ep.reseed_req_o), 128'h1);
    chk("stalled_words", 128'(ep.words_o), 128'(RI));

    step(1'b0, 1'b1, 128'h0, ga, gr, sk);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, '0, ga, gr, sk);
    chk("idle_buffer", ep._ep_res_0, stepn(DSEED, S));

    step(1'b1, 1'b1, 128'hDEAD_BEEF, ga, gr, sk);
    chk("collide_ack", 128'(ga), 128'h1);
    chk("collide_word", gr, stepn(DSEED, S));
    step(1'b1, 1'b1, 128'hDEAD_BEEF, ga, gr, sk);
    for (int i = 0; i <= S; i++) step(1'b1, 1'b0, '0, ga, gr, sk);
    chk("new_seed_word", gr, stepn(128'hDEAD_BEEF, S));

    step(1'b1, 1'b0, '0, ga, gr, sk);
    do_reset();
    for (int i = 0; i <= S; i++) step(1'b1, 1'b0, '0, ga, gr, sk);

    sv_hold = 1'b0;
    sd_hold = '0;
    for (int i = 0; i < 2500; i++) begin
      if (!sv_hold && ($urandom % 40 == 0)) begin
        sv_hold = 1'b1;
        sd_hold = ($urandom % 4 == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
      end
      step(($urandom % 4) != 0, sv_hold, sd_hold, ga, gr, sk);
      if (sk) sv_hold = 1'b0;
      if ($urandom % 600 == 0) begin
        do_reset();
        sv_hold = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
